// File: rtl/text_screen_ram_fill.sv
// text_screen_ram_fill: single-clock text-cell RAM with a CPU port, a video port and a
// rectangular block-fill engine.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cs_i, we_i, sel_i,    CPU access: one-cycle request, write enable, byte lanes,
//   adr_i, dat_i          cell address, write data
//   dat_o, ack_o          CPU read data (held until the next read), one-cycle completion pulse
//   vcs_i, vadr_i, vdat_o video read port, one cycle latency, read-first against writes
//   fill_start_i          starts a fill from IDLE; parameters below are latched at that edge
//   fill_adr_i            top-left cell of the rectangle
//   fill_cols_i/rows_i    rectangle size; either being zero completes without writing
//   fill_pitch_i          address step between row start cells
//   fill_dat_i            fill value
//   fill_sel_i            fill byte lanes (only with TSR_FILL_MASK_EN defined)
//   fill_busy_o           engine running
//   fill_done_o           one-cycle pulse when the fill completes
//
// Build option: define TSR_FILL_MASK_EN to add fill_sel_i; otherwise fills write all lanes.
// The fill engine only writes on cycles with cs_i low, so the CPU is never stalled.

module text_screen_ram_fill #(
   parameter int unsigned CELL_COUNT = 16384,
   parameter int unsigned WID        = 64,
   parameter int unsigned RD_LAT     = 2,
   localparam int unsigned AWID      = $clog2(CELL_COUNT),
   localparam int unsigned NSEL      = WID / 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cs_i,
   input  logic            we_i,
   input  logic [NSEL-1:0] sel_i,
   input  logic [AWID-1:0] adr_i,
   input  logic [WID-1:0]  dat_i,
   output logic [WID-1:0]  dat_o,
   output logic            ack_o,
   input  logic            vcs_i,
   input  logic [AWID-1:0] vadr_i,
   output logic [WID-1:0]  vdat_o,
   input  logic            fill_start_i,
   input  logic [AWID-1:0] fill_adr_i,
   input  logic [AWID-1:0] fill_cols_i,
   input  logic [AWID-1:0] fill_rows_i,
   input  logic [AWID-1:0] fill_pitch_i,
   input  logic [WID-1:0]  fill_dat_i,
`ifdef TSR_FILL_MASK_EN
   input  logic [NSEL-1:0] fill_sel_i,
`endif
   output logic            fill_busy_o,
   output logic            fill_done_o
);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("text_screen_ram_fill: RD_LAT must be 1 or 2");
   end

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q;
   logic [AWID-1:0] rowbase_q;
   logic [AWID-1:0] col_q;
   logic [AWID-1:0] row_q;
   logic [AWID-1:0] cols_q;
   logic [AWID-1:0] rows_q;
   logic [AWID-1:0] pitch_q;
   logic [WID-1:0]  fdat_q;
   logic [NSEL-1:0] fill_lanes;
`ifdef TSR_FILL_MASK_EN
   logic [NSEL-1:0] fsel_q;
`endif

   logic [WID-1:0]  mem [0:CELL_COUNT-1];

   logic            cpu_wr;
   logic            cpu_rd;
   logic            fill_wr;
   logic            wr_en;
   logic [AWID-1:0] wr_adr;
   logic [WID-1:0]  wr_dat;
   logic [NSEL-1:0] wr_sel;
   logic [AWID-1:0] last_col;
   logic [AWID-1:0] last_row;

   logic [WID-1:0]  rd_data_q;
   logic            rd_pend_q;

`ifdef TSR_FILL_MASK_EN
   assign fill_lanes = fsel_q;
`else
   assign fill_lanes = '1;
`endif

   assign last_col = cols_q - AWID'(1);
   assign last_row = rows_q - AWID'(1);

   // Single write port shared by CPU and fill engine; fill only uses cycles with cs_i low,
   // and never writes on a reset edge so an aborted fill stops immediately.
   always_comb begin
      cpu_wr  = cs_i & we_i;
      cpu_rd  = cs_i & ~we_i;
      fill_wr = (state_q == StRun) & ~cs_i & ~rst_i;
      wr_en   = cpu_wr | fill_wr;
      wr_adr  = adr_i;
      wr_dat  = dat_i;
      wr_sel  = sel_i;
      if (fill_wr) begin
         wr_adr = rowbase_q + col_q;
         wr_dat = fdat_q;
         wr_sel = fill_lanes;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < NSEL; b++) begin
            if (wr_sel[b]) begin
               mem[wr_adr][b*8 +: 8] <= wr_dat[b*8 +: 8];
            end
         end
      end
   end

   // CPU read pipeline; writes acknowledge one cycle after the request regardless of RD_LAT.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
         rd_pend_q <= 1'b0;
         dat_o     <= '0;
         ack_o     <= 1'b0;
      end else begin
         rd_pend_q <= cpu_rd;
         if (cpu_rd) begin
            rd_data_q <= mem[adr_i];
         end
         if (RD_LAT == 1) begin
            ack_o <= cs_i;
            if (cpu_rd) begin
               dat_o <= mem[adr_i];
            end
         end else begin
            ack_o <= cpu_wr | rd_pend_q;
            if (rd_pend_q) begin
               dat_o <= rd_data_q;
            end
         end
      end
   end

   // Video port: read-first falls out of the non-blocking memory update.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vdat_o <= '0;
      end else if (vcs_i) begin
         vdat_o <= mem[vadr_i];
      end
   end

   // Fill engine. busy/done are registered alongside the state so they match it exactly.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         fill_busy_o <= 1'b0;
         fill_done_o <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fill_start_i) begin
                  rowbase_q <= fill_adr_i;
                  cols_q    <= fill_cols_i;
                  rows_q    <= fill_rows_i;
                  pitch_q   <= fill_pitch_i;
                  fdat_q    <= fill_dat_i;
`ifdef TSR_FILL_MASK_EN
                  fsel_q    <= fill_sel_i;
`endif
                  col_q     <= '0;
                  row_q     <= '0;
                  if (fill_cols_i == '0 || fill_rows_i == '0) begin
                     state_q     <= StDone;
                     fill_done_o <= 1'b1;
                  end else begin
                     state_q     <= StRun;
                     fill_busy_o <= 1'b1;
                  end
               end
            end
            StRun: begin
               // Any CPU request stalls the engine with counters held.
               if (!cs_i) begin
                  if (col_q == last_col) begin
                     col_q     <= '0;
                     rowbase_q <= rowbase_q + pitch_q;
                     row_q     <= row_q + AWID'(1);
                     if (row_q == last_row) begin
                        state_q     <= StDone;
                        fill_busy_o <= 1'b0;
                        fill_done_o <= 1'b1;
                     end
                  end else begin
                     col_q <= col_q + AWID'(1);
                  end
               end
            end
            StDone: begin
               fill_done_o <= 1'b0;
               state_q     <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_text_screen_ram_fill.sv
// Directed bench for text_screen_ram_fill. Two instances share all inputs: one with RD_LAT=2
// (main checks) and one with RD_LAT=1 (read-latency checks in the vector table).

module tb_text_screen_ram_fill;

   localparam int unsigned CC   = 1024;
   localparam int unsigned AW   = 10;
   localparam int unsigned W    = 64;
   localparam int unsigned NS   = 8;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          cs_i = 1'b0;
   logic          we_i = 1'b0;
   logic [NS-1:0] sel_i = '0;
   logic [AW-1:0] adr_i = '0;
   logic [W-1:0]  dat_i = '0;
   logic          vcs_i = 1'b0;
   logic [AW-1:0] vadr_i = '0;
   logic          fill_start_i = 1'b0;
   logic [AW-1:0] fill_adr_i = '0;
   logic [AW-1:0] fill_cols_i = '0;
   logic [AW-1:0] fill_rows_i = '0;
   logic [AW-1:0] fill_pitch_i = '0;
   logic [W-1:0]  fill_dat_i = '0;
   logic [NS-1:0] fill_sel_i = '1;

   logic [W-1:0]  dat_o, vdat_o, dat1_o, vdat1_o;
   logic          ack_o, fill_busy_o, fill_done_o;
   logic          ack1_o, busy1_o, done1_o;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] rd_exp = '0;

   always #5 clk = ~clk;

   text_screen_ram_fill #(.CELL_COUNT(CC), .WID(W), .RD_LAT(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .cs_i(cs_i), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i),
      .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .vcs_i(vcs_i), .vadr_i(vadr_i),
      .vdat_o(vdat_o), .fill_start_i(fill_start_i), .fill_adr_i(fill_adr_i),
      .fill_cols_i(fill_cols_i), .fill_rows_i(fill_rows_i), .fill_pitch_i(fill_pitch_i),
      .fill_dat_i(fill_dat_i),
`ifdef TSR_FILL_MASK_EN
      .fill_sel_i(fill_sel_i),
`endif
      .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o)
   );

   text_screen_ram_fill #(.CELL_COUNT(CC), .WID(W), .RD_LAT(1)) dut_l1 (
      .clk_i(clk), .rst_i(rst_i), .cs_i(cs_i), .we_i(we_i), .sel_i(sel_i), .adr_i(adr_i),
      .dat_i(dat_i), .dat_o(dat1_o), .ack_o(ack1_o), .vcs_i(vcs_i), .vadr_i(vadr_i),
      .vdat_o(vdat1_o), .fill_start_i(fill_start_i), .fill_adr_i(fill_adr_i),
      .fill_cols_i(fill_cols_i), .fill_rows_i(fill_rows_i), .fill_pitch_i(fill_pitch_i),
      .fill_dat_i(fill_dat_i),
`ifdef TSR_FILL_MASK_EN
      .fill_sel_i(fill_sel_i),
`endif
      .fill_busy_o(busy1_o), .fill_done_o(done1_o)
   );

   typedef struct {
      logic          cs;
      logic          we;
      logic [NS-1:0] sel;
      logic [AW-1:0] adr;
      logic [W-1:0]  dat;
      logic          vcs;
      logic [AW-1:0] vadr;
      logic          ack2;
      logic [W-1:0]  dat2;
      logic          ack1;
      logic [W-1:0]  dat1;
      logic [W-1:0]  vdat;
   } vec_t;

   vec_t vecs[7];

   function automatic logic [W-1:0] pat(input logic [AW-1:0] a);
      return 64'hC0DE_0000_0000_0000 | 64'(a);
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic cpu_write(input logic [AW-1:0] a, input logic [W-1:0] d);
      cs_i = 1'b1; we_i = 1'b1; sel_i = '1; adr_i = a; dat_i = d;
      @(negedge clk);
      cs_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic vread(input logic [AW-1:0] a, output logic [W-1:0] d);
      vcs_i = 1'b1; vadr_i = a;
      @(negedge clk);
      d = vdat_o;
      vcs_i = 1'b0;
   endtask

   // Pattern the rectangle plus one cell either side of each row.
   task automatic prefill_rect(input int a, input int c, input int r, input int p);
      for (int row = 0; row < r; row++) begin
         for (int col = -1; col <= c; col++) begin
            cpu_write(AW'(a + row * p + col), pat(AW'(a + row * p + col)));
         end
      end
   endtask

   task automatic check_rect(input int a, input int c, input int r, input int p,
                             input logic [W-1:0] d);
      logic [W-1:0] got;
      logic [AW-1:0] ca;
      for (int row = 0; row < r; row++) begin
         for (int col = -1; col <= c; col++) begin
            ca = AW'(a + row * p + col);
            vread(ca, got);
            check($sformatf("cell %0d", ca), got, (col >= 0 && col < c) ? d : pat(ca));
         end
      end
   endtask

   // Start a fill and count busy cycles. stall_mask bit k drives a CPU read of 0x010 in busy
   // cycle k; poke_start re-pulses fill_start with other values in busy cycle 1.
   task automatic run_fill(input logic [AW-1:0] a, c, r, p, input logic [W-1:0] d,
                           input logic [31:0] stall_mask, input bit poke_start,
                           output int busy_cnt, output int acks, output logic done);
      fill_adr_i = a; fill_cols_i = c; fill_rows_i = r; fill_pitch_i = p; fill_dat_i = d;
      fill_start_i = 1'b1;
      @(negedge clk);
      fill_start_i = 1'b0;
      busy_cnt = 0;
      acks = 0;
      while (fill_busy_o && busy_cnt < 100) begin
         busy_cnt++;
         if (ack_o) begin
            acks++;
            check("stall read data", dat_o, rd_exp);
         end
         cs_i = stall_mask[busy_cnt % 32]; we_i = 1'b0; adr_i = 10'h010;
         if (poke_start && busy_cnt == 1) begin
            fill_start_i = 1'b1; fill_adr_i = 10'd400; fill_cols_i = 10'd1;
            fill_rows_i = 10'd1; fill_dat_i = 64'h88;
         end else begin
            fill_start_i = 1'b0;
         end
         @(negedge clk);
      end
      cs_i = 1'b0;
      fill_start_i = 1'b0;
      done = fill_done_o;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bc, ac;
      logic dn;
      logic [W-1:0] got;
      logic [W-1:0] va, vb;

      va = 64'h1122334455667788;
      vb = 64'h11223344FFFFFFFF;
      // cs we sel adr dat vcs vadr | ack2 dat2 | ack1 dat1 | vdat
      vecs[0] = '{1'b1, 1'b1, 8'hFF, 10'h010, va, 1'b0, 10'h000, 1'b1, '0, 1'b1, '0, '0};
      vecs[1] = '{1'b1, 1'b0, 8'hFF, 10'h010, '0, 1'b0, 10'h000, 1'b0, '0, 1'b1, va, '0};
      vecs[2] = '{1'b0, 1'b0, 8'h00, 10'h000, '0, 1'b0, 10'h000, 1'b1, va, 1'b0, va, '0};
      vecs[3] = '{1'b1, 1'b1, 8'h0F, 10'h010, '1, 1'b1, 10'h010, 1'b1, va, 1'b1, va, va};
      vecs[4] = '{1'b1, 1'b0, 8'hFF, 10'h010, '0, 1'b1, 10'h010, 1'b0, va, 1'b1, vb, vb};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 10'h000, '0, 1'b0, 10'h000, 1'b1, vb, 1'b0, vb, vb};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 10'h000, '0, 1'b0, 10'h000, 1'b0, vb, 1'b0, vb, vb};

      // Reset
      @(negedge clk);
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      check("reset dat_o", dat_o, '0);
      check("reset vdat_o", vdat_o, '0);
      check("reset ack_o", 64'(ack_o), '0);
      check("reset busy", 64'(fill_busy_o), '0);
      check("reset done", 64'(fill_done_o), '0);

      // CPU write/read, partial write and read-first video port
      for (int i = 0; i < 7; i++) begin
         cs_i = vecs[i].cs; we_i = vecs[i].we; sel_i = vecs[i].sel; adr_i = vecs[i].adr;
         dat_i = vecs[i].dat; vcs_i = vecs[i].vcs; vadr_i = vecs[i].vadr;
         @(negedge clk);
         check($sformatf("v%0d ack lat2", i), 64'(ack_o), 64'(vecs[i].ack2));
         check($sformatf("v%0d dat lat2", i), dat_o, vecs[i].dat2);
         check($sformatf("v%0d ack lat1", i), 64'(ack1_o), 64'(vecs[i].ack1));
         check($sformatf("v%0d dat lat1", i), dat1_o, vecs[i].dat1);
         check($sformatf("v%0d vdat", i), vdat_o, vecs[i].vdat);
      end
      cs_i = 1'b0; we_i = 1'b0; vcs_i = 1'b0;
      rd_exp = vb;

      // Fill 4x3 at 100, pitch 80, CPU idle
      prefill_rect(100, 4, 3, 80);
      run_fill(10'd100, 10'd4, 10'd3, 10'd80, 64'h20, 32'h0, 1'b0, bc, ac, dn);
      check("fill busy cycles", 64'(bc), 64'd12);
      check("fill done pulse", 64'(dn), 64'd1);
      @(negedge clk);
      check("fill done one cycle", 64'(fill_done_o), 64'd0);
      check_rect(100, 4, 3, 80, 64'h20);

      // Same fill with CPU reads on busy cycles 2, 3, 7
      prefill_rect(100, 4, 3, 80);
      run_fill(10'd100, 10'd4, 10'd3, 10'd80, 64'h20, 32'h8C, 1'b0, bc, ac, dn);
      check("stalled busy cycles", 64'(bc), 64'd15);
      check("stalled read acks", 64'(ac), 64'd3);
      check("stalled done pulse", 64'(dn), 64'd1);
      @(negedge clk);
      check_rect(100, 4, 3, 80, 64'h20);

      // Wrap around the top of the address space
      prefill_rect(CC - 2, 4, 1, 0);
      run_fill(10'(CC - 2), 10'd4, 10'd1, 10'd0, 64'h55, 32'h0, 1'b0, bc, ac, dn);
      check("wrap busy cycles", 64'(bc), 64'd4);
      check("wrap done", 64'(dn), 64'd1);
      @(negedge clk);
      check_rect(CC - 2, 4, 1, 0, 64'h55);

      // Degenerate fill: cols=0 gives done after one cycle and no writes
      run_fill(10'd100, 10'd0, 10'd3, 10'd80, 64'h99, 32'h0, 1'b0, bc, ac, dn);
      check("cols0 busy cycles", 64'(bc), 64'd0);
      check("cols0 done", 64'(dn), 64'd1);
      @(negedge clk);
      check("cols0 done one cycle", 64'(fill_done_o), 64'd0);
      vread(10'd100, got);
      check("cols0 no write", got, 64'h20);

      // Start while busy and while done is ignored
      prefill_rect(300, 2, 2, 10);
      cpu_write(10'd400, pat(10'd400));
      cpu_write(10'd500, pat(10'd500));
      run_fill(10'd300, 10'd2, 10'd2, 10'd10, 64'h77, 32'h0, 1'b1, bc, ac, dn);
      check("busy restart cycles", 64'(bc), 64'd4);
      check("busy restart done", 64'(dn), 64'd1);
      fill_adr_i = 10'd500; fill_cols_i = 10'd1; fill_rows_i = 10'd1; fill_dat_i = 64'h66;
      fill_start_i = 1'b1;
      @(negedge clk);
      fill_start_i = 1'b0;
      check("start in done ignored", 64'(fill_busy_o), 64'd0);
      @(negedge clk);
      check("still idle", 64'(fill_busy_o), 64'd0);
      check_rect(300, 2, 2, 10, 64'h77);
      vread(10'd400, got);
      check("cell 400 untouched", got, pat(10'd400));
      vread(10'd500, got);
      check("cell 500 untouched", got, pat(10'd500));

`ifdef TSR_FILL_MASK_EN
      // Lane-masked fill keeps the low bytes
      prefill_rect(700, 2, 1, 0);
      fill_sel_i = 8'hF0;
      run_fill(10'd700, 10'd2, 10'd1, 10'd0, '1, 32'h0, 1'b0, bc, ac, dn);
      fill_sel_i = '1;
      check("mask done", 64'(dn), 64'd1);
      @(negedge clk);
      for (int k = 700; k < 702; k++) begin
         vread(AW'(k), got);
         check($sformatf("mask cell %0d", k), got, {32'hFFFF_FFFF, pat(AW'(k))[31:0]});
      end
`endif

      // Reset after five fill writes
      prefill_rect(600, 10, 1, 0);
      fill_adr_i = 10'd600; fill_cols_i = 10'd10; fill_rows_i = 10'd1; fill_pitch_i = '0;
      fill_dat_i = 64'h33;
      fill_start_i = 1'b1;
      @(negedge clk);
      fill_start_i = 1'b0;
      repeat (5) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("abort busy", 64'(fill_busy_o), 64'd0);
      check("abort done", 64'(fill_done_o), 64'd0);
      check("abort dat_o", dat_o, '0);
      check("abort ack_o", 64'(ack_o), 64'd0);
      dn = 1'b0;
      repeat (4) begin
         @(negedge clk);
         dn = dn | fill_done_o | fill_busy_o;
      end
      check("abort no done later", 64'(dn), 64'd0);
      for (int k = 600; k < 610; k++) begin
         vread(AW'(k), got);
         check($sformatf("abort cell %0d", k), got, (k < 605) ? 64'h33 : pat(AW'(k)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
